// File: rtl/rf_host_master_pkg.sv
// Shared types and status codes for the register-file host master.
package rf_host_master_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_INVALID = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;

endpackage

// File: rtl/rf_host_master.sv
// Host-side initiator: turns one valid/ready command into an RF strobe, waits
// for completion, invalid address or timeout, and returns a held response.
//
// state | meaning
// IDLE  | ready for a command; command fields captured on accept
// ISSUE | single-cycle read_en/write_en strobe, timeout counter cleared
// WAIT  | waiting for access_complete / invalid_address or timeout
// RESP  | response held until rsp_ready
module rf_host_master
   import rf_host_master_pkg::*;
#(
   parameter int ADDR_MSB       = 8,
   parameter int ADDR_LSB       = 3,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       res,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [ADDR_MSB-ADDR_LSB:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0]      cmd_wdata,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_WIDTH-1:0]      rsp_rdata,
   output logic [1:0]                 rsp_status,
   output logic [ADDR_MSB:ADDR_LSB]   address,
   output logic                       read_en,
   output logic                       write_en,
   output logic [DATA_WIDTH-1:0]      write_data,
   input  logic [DATA_WIDTH-1:0]      read_data,
   input  logic                       invalid_address,
   input  logic                       access_complete,
   output logic                       busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             is_write;
   logic             accept;
   logic             done_ok;
   logic             done_inv;
   logic             done_to;

   always_ff @(posedge clk) begin
      if (res) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done_ok   = 1'b0;
      done_inv  = 1'b0;
      done_to   = 1'b0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy      = 1'b0;
            cmd_ready = !res;
            if (cmd_valid && !res) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            // invalid_address outranks access_complete; either beats the timeout
            if (invalid_address) begin
               done_inv  = 1'b1;
               state_nxt = RESP;
            end else if (access_complete) begin
               done_ok   = 1'b1;
               state_nxt = RESP;
            end else if (cnt >= CNT_LAST) begin
               done_to   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         address    <= '0;
         write_data <= '0;
         is_write   <= 1'b0;
         read_en    <= 1'b0;
         write_en   <= 1'b0;
         cnt        <= '0;
         rsp_rdata  <= '0;
         rsp_status <= ST_OK;
      end else begin
         read_en  <= 1'b0;
         write_en <= 1'b0;
         if (accept) begin
            address    <= cmd_addr;
            write_data <= cmd_wdata;
            is_write   <= cmd_write;
            read_en    <= !cmd_write;
            write_en   <= cmd_write;
         end

         if (state == ISSUE) begin
            cnt <= '0;
         end else if (state == WAIT && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end

         if (done_ok) begin
            rsp_rdata  <= is_write ? '0 : read_data;
            rsp_status <= ST_OK;
         end else if (done_inv) begin
            rsp_rdata  <= '0;
            rsp_status <= ST_INVALID;
         end else if (done_to) begin
            rsp_rdata  <= '0;
            rsp_status <= ST_TIMEOUT;
         end
      end
   end

endmodule
